dmem_port_ctrl: RTL and testbench
=================================

Name: dmem_port_ctrl

Overview:
Two-requester controller in front of the single-port 2 KB data memory (11-bit byte address, 32-bit word, 4-bit byte mask, combinational read).
- Port 0 is the core load/store unit; port 1 is the DMA/debug master.
- The block arbitrates between the two ports and converts size/offset into the memory's byte-mask encoding.
- It rejects misaligned or illegal accesses, sign/zero-extends load data, and returns a registered response per port with valid/ready backpressure.

Parameters:
ADDR_W, 11, byte address width (matches memory)
DATA_W, 32, data width
FIXED_PRIO, 0, 0 = round-robin; 1 = port 0 always wins

Ports:
i_clk  input  1  clock
i_reset  input  1  synchronous active-high reset
i_p0_req_valid / i_p1_req_valid  input  1  request valid
o_p0_req_ready / o_p1_req_ready  output  1  request accepted this cycle (grant)
i_p0_addr / i_p1_addr  input  ADDR_W  byte address
i_p0_wdata / i_p1_wdata  input  DATA_W  store data, right-aligned (byte in [7:0], half in [15:0])
i_p0_size / i_p1_size  input  2  00 byte, 01 half, 10 word, 11 illegal
i_p0_unsigned / i_p1_unsigned  input  1  1 = zero-extend loads, 0 = sign-extend
i_p0_we / i_p1_we  input  1  1 = store, 0 = load
o_p0_rsp_valid / o_p1_rsp_valid  output  1  response valid
i_p0_rsp_ready / i_p1_rsp_ready  input  1  response consumed
o_p0_rsp_rdata / o_p1_rsp_rdata  output  DATA_W  extended load data; 0 for stores and errors
o_p0_rsp_err / o_p1_rsp_err  output  1  misaligned or illegal-size access
o_mem_addr  output  ADDR_W  memory byte address
o_mem_wdata  output  DATA_W  memory write data
o_mem_bmask  output  4  1111 word, 0011 half, 0001 byte, 0000 idle/rejected
o_mem_wren  output  1  memory write enable
i_mem_rdata  input  DATA_W  memory read data, already shifted right by byte offset

Behaviour:
Reset values:
- All rsp_valid/rsp_err = 0, rsp_rdata = 0.
- Round-robin pointer = "port 1 last granted", so port 0 wins the first tie.
- While i_reset is high, both req_ready = 0 and o_mem_wren = 0.

Eligibility and grant:
- Port N is eligible when req_valid_N and (!rsp_valid_N or rsp_ready_N).
- A port blocked by its own pending response never blocks the other port.
- Arbitration is combinational. With one eligible port, grant it. With both eligible, grant the port not last granted (FIXED_PRIO=1: always port 0).
- The pointer updates only on a grant.
- At most one grant per cycle. req_ready_N = grant_N.

Alignment and size checks:
- Legal: byte at any address; half when addr[0]=0; word when addr[1:0]=00.
- Size 11 is illegal.

Memory drive:
- Granted and legal: o_mem_addr = addr, o_mem_wdata = wdata, o_mem_bmask per size, o_mem_wren = we.
- No grant, or granted but illegal: addr=0, wdata=0, bmask=0000, wren=0. Rejected stores never reach memory.

Response timing:
- A request accepted at cycle T produces rsp_valid_N=1 at T+1.
- The response register captures at the T/T+1 edge:
  - err = illegal.
  - Load word: i_mem_rdata.
  - Load half: {16{sign}, [15:0]} with sign = unsigned ? 0 : bit15.
  - Load byte: same rule on [7:0].
  - Stores and errors: rdata = 0.
- The response holds stable while rsp_ready_N=0.
- rsp_valid_N clears on rsp_ready_N unless a new grant to N occurs the same cycle, in which case the new response replaces it (back-to-back throughput of 1/cycle per port).

Ordering and hazards:
- A store accepted at T is committed at the T edge. A load accepted at T+1 or later (either port) sees the new data.

Mid-operation reset:
- Any captured response is discarded and the pointer resets.
- Requesters must re-issue.

Decomposition:
- Package dmem_ctrl_pkg contains:
  - size enum (SZ_BYTE, SZ_HALF, SZ_WORD, SZ_ILL);
  - bmask constants (BM_WORD=1111, BM_HALF=0011, BM_BYTE=0001, BM_NONE=0000);
  - function load_extend(size, unsigned, data);
  - function is_aligned(size, addr[1:0]).
- One sub-module: dmem_rr_arb2, a 2-way round-robin arbiter with FIXED_PRIO, inputs eligible[1:0], outputs grant[1:0], with its own pointer register.

Test Plan:
- p0 store word 0xDEADBEEF @0x010, then p0 load byte unsigned @0x013 -> rsp_rdata=0x000000DE one cycle after accept; signed -> 0xFFFFFFDE.
- p0 load half signed @0x012 -> 0xFFFFDEAD. p1 store byte 0xAA @0x011, then load word @0x010 -> 0xDEADAAEF.
- p0 store half @0x011 (misaligned) and size=11 @0x000 -> rsp_err=1, rdata=0, o_mem_wren=0 both cycles; memory word @0x010 unchanged.
- Both ports request continuously with rsp_ready=1 -> grants alternate p0,p1,p0,p1. With FIXED_PRIO=1 -> p0 every cycle, p1 starved.
- p1 rsp_ready=0 with pending response and new p1 request -> p1 req_ready=0 and response held stable; p0 requests still granted each cycle; raising p1 rsp_ready grants p1 the same cycle.
- Assert i_reset for 1 cycle while both responses are pending -> next cycle rsp_valid=0 on both ports and mem_wren=0; first post-reset tie grants p0.

Source files
------------

// File: rtl/dmem_ctrl_pkg.sv
// Shared types and helpers for the data-memory port controller:
// access size encoding, byte-mask constants, alignment check and load extension.
package dmem_ctrl_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  localparam logic [3:0] BM_WORD = 4'b1111;
  localparam logic [3:0] BM_HALF = 4'b0011;
  localparam logic [3:0] BM_BYTE = 4'b0001;
  localparam logic [3:0] BM_NONE = 4'b0000;

  // Also covers the illegal size code, so a false result means "reject".
  function automatic logic is_aligned(input size_e size, input logic [1:0] addr_lo);
    logic ok;
    ok = 1'b0;
    case (size)
      SZ_BYTE: ok = 1'b1;
      SZ_HALF: ok = ~addr_lo[0];
      SZ_WORD: ok = (addr_lo == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [3:0] size_bmask(input size_e size);
    logic [3:0] bm;
    bm = BM_NONE;
    case (size)
      SZ_BYTE: bm = BM_BYTE;
      SZ_HALF: bm = BM_HALF;
      SZ_WORD: bm = BM_WORD;
      default: bm = BM_NONE;
    endcase
    return bm;
  endfunction

  // Memory data arrives already shifted down by the byte offset.
  function automatic logic [31:0] load_extend(input size_e size, input logic zext,
                                              input logic [31:0] data);
    logic        sign;
    logic [31:0] res;
    sign = 1'b0;
    res  = '0;
    case (size)
      SZ_BYTE: begin
        sign = ~zext & data[7];
        res  = {{24{sign}}, data[7:0]};
      end
      SZ_HALF: begin
        sign = ~zext & data[15];
        res  = {{16{sign}}, data[15:0]};
      end
      SZ_WORD: res = data;
      default: res = '0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/dmem_rr_arb2.sv
// Two-way arbiter: round-robin on ties, or port 0 always wins when FIXED_PRIO is set.
// The pointer only moves when something is granted.
module dmem_rr_arb2 #(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] eligible,
  output logic [1:0] grant
);

  logic last_p1;

  // Reset to "port 1 last" so port 0 takes the first tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_p1 <= 1'b1;
    end else if (|grant) begin
      last_p1 <= grant[1];
    end
  end

  always_comb begin
    grant = eligible;
    if (&eligible) begin
      grant = (FIXED_PRIO || last_p1) ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/dmem_port_ctrl.sv
// Two-requester front end for the single-port 2 KB data memory: arbitration,
// size/alignment checking, byte-mask generation and registered per-port responses.
module dmem_port_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int ADDR_W     = 11,
  parameter int DATA_W     = 32,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_p0_req_valid,
  output logic              o_p0_req_ready,
  input  logic [ADDR_W-1:0] i_p0_addr,
  input  logic [DATA_W-1:0] i_p0_wdata,
  input  logic [1:0]        i_p0_size,
  input  logic              i_p0_unsigned,
  input  logic              i_p0_we,
  output logic              o_p0_rsp_valid,
  input  logic              i_p0_rsp_ready,
  output logic [DATA_W-1:0] o_p0_rsp_rdata,
  output logic              o_p0_rsp_err,
  input  logic              i_p1_req_valid,
  output logic              o_p1_req_ready,
  input  logic [ADDR_W-1:0] i_p1_addr,
  input  logic [DATA_W-1:0] i_p1_wdata,
  input  logic [1:0]        i_p1_size,
  input  logic              i_p1_unsigned,
  input  logic              i_p1_we,
  output logic              o_p1_rsp_valid,
  input  logic              i_p1_rsp_ready,
  output logic [DATA_W-1:0] o_p1_rsp_rdata,
  output logic              o_p1_rsp_err,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic [3:0]        o_mem_bmask,
  output logic              o_mem_wren,
  input  logic [DATA_W-1:0] i_mem_rdata
);

  logic [1:0]             req_valid;
  logic [1:0]             rsp_ready;
  logic [1:0]             eligible;
  logic [1:0]             grant;
  logic [1:0]             rsp_valid_q;
  logic [1:0]             rsp_err_q;
  logic [1:0][DATA_W-1:0] rsp_rdata_q;

  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  size_e             sel_size;
  logic              sel_zext;
  logic              sel_we;
  logic              sel_legal;
  logic              any_grant;
  logic [DATA_W-1:0] rsp_data_next;

  assign req_valid = {i_p1_req_valid, i_p0_req_valid};
  assign rsp_ready = {i_p1_rsp_ready, i_p0_rsp_ready};

  // A port stalled on its own unconsumed response drops out of arbitration.
  assign eligible = req_valid & (~rsp_valid_q | rsp_ready) & {2{~i_reset}};

  dmem_rr_arb2 #(
    .FIXED_PRIO(FIXED_PRIO)
  ) u_arb (
    .clk     (i_clk),
    .reset   (i_reset),
    .eligible(eligible),
    .grant   (grant)
  );

  always_comb begin
    if (grant[1]) begin
      sel_addr  = i_p1_addr;
      sel_wdata = i_p1_wdata;
      sel_size  = size_e'(i_p1_size);
      sel_zext  = i_p1_unsigned;
      sel_we    = i_p1_we;
    end else begin
      sel_addr  = i_p0_addr;
      sel_wdata = i_p0_wdata;
      sel_size  = size_e'(i_p0_size);
      sel_zext  = i_p0_unsigned;
      sel_we    = i_p0_we;
    end
  end

  assign any_grant = |grant;
  assign sel_legal = is_aligned(sel_size, sel_addr[1:0]);

  // Rejected accesses present an idle bus so a bad store can never land.
  always_comb begin
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    o_mem_bmask = BM_NONE;
    o_mem_wren  = 1'b0;
    if (any_grant && sel_legal) begin
      o_mem_addr  = sel_addr;
      o_mem_wdata = sel_wdata;
      o_mem_bmask = size_bmask(sel_size);
      o_mem_wren  = sel_we;
    end
  end

  assign rsp_data_next = (sel_legal && !sel_we) ?
                         load_extend(sel_size, sel_zext, i_mem_rdata) : '0;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rsp_valid_q <= '0;
      rsp_err_q   <= '0;
      rsp_rdata_q <= '0;
    end else begin
      for (int n = 0; n < 2; n++) begin
        if (grant[n]) begin
          rsp_valid_q[n] <= 1'b1;
          rsp_err_q[n]   <= ~sel_legal;
          rsp_rdata_q[n] <= rsp_data_next;
        end else if (rsp_ready[n]) begin
          rsp_valid_q[n] <= 1'b0;
        end
      end
    end
  end

  assign o_p0_req_ready = grant[0];
  assign o_p1_req_ready = grant[1];
  assign o_p0_rsp_valid = rsp_valid_q[0];
  assign o_p1_rsp_valid = rsp_valid_q[1];
  assign o_p0_rsp_err   = rsp_err_q[0];
  assign o_p1_rsp_err   = rsp_err_q[1];
  assign o_p0_rsp_rdata = rsp_rdata_q[0];
  assign o_p1_rsp_rdata = rsp_rdata_q[1];

endmodule

// File: tb/tb_dmem_port_ctrl.sv
// Self-checking bench for dmem_port_ctrl: byte-array memory model, directed table,
// randomized accesses against a byte-level reference, arbitration and reset scenarios.
`timescale 1ns/1ps
module tb_dmem_port_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [1:0]  req_valid, rsp_ready, we, zext;
  logic [10:0] addr  [2];
  logic [31:0] wdata [2];
  logic [1:0]  size  [2];
  logic [1:0]  req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata [2];
  logic [10:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [3:0]  mem_bmask;
  logic        mem_wren;

  logic [1:0]  fp_valid, fp_ready, fp_rsp_valid, fp_rsp_err;
  logic [31:0] fp_rdata [2];
  logic [10:0] fp_mem_addr;
  logic [31:0] fp_mem_wdata;
  logic [3:0]  fp_mem_bmask;
  logic        fp_mem_wren;

  logic [7:0] mem     [2048] = '{default: 8'h00};
  logic [7:0] ref_mem [2048] = '{default: 8'h00};

  int tests = 0;
  int fails = 0;
  int last_grant = 1;

  dmem_port_ctrl dut (
    .i_clk(clk), .i_reset(reset),
    .i_p0_req_valid(req_valid[0]), .o_p0_req_ready(req_ready[0]), .i_p0_addr(addr[0]),
    .i_p0_wdata(wdata[0]), .i_p0_size(size[0]), .i_p0_unsigned(zext[0]), .i_p0_we(we[0]),
    .o_p0_rsp_valid(rsp_valid[0]), .i_p0_rsp_ready(rsp_ready[0]),
    .o_p0_rsp_rdata(rsp_rdata[0]), .o_p0_rsp_err(rsp_err[0]),
    .i_p1_req_valid(req_valid[1]), .o_p1_req_ready(req_ready[1]), .i_p1_addr(addr[1]),
    .i_p1_wdata(wdata[1]), .i_p1_size(size[1]), .i_p1_unsigned(zext[1]), .i_p1_we(we[1]),
    .o_p1_rsp_valid(rsp_valid[1]), .i_p1_rsp_ready(rsp_ready[1]),
    .o_p1_rsp_rdata(rsp_rdata[1]), .o_p1_rsp_err(rsp_err[1]),
    .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .o_mem_bmask(mem_bmask),
    .o_mem_wren(mem_wren), .i_mem_rdata(mem_rdata)
  );

  dmem_port_ctrl #(.FIXED_PRIO(1'b1)) dut_fp (
    .i_clk(clk), .i_reset(reset),
    .i_p0_req_valid(fp_valid[0]), .o_p0_req_ready(fp_ready[0]), .i_p0_addr(11'h000),
    .i_p0_wdata(32'h0), .i_p0_size(2'b10), .i_p0_unsigned(1'b0), .i_p0_we(1'b0),
    .o_p0_rsp_valid(fp_rsp_valid[0]), .i_p0_rsp_ready(1'b1),
    .o_p0_rsp_rdata(fp_rdata[0]), .o_p0_rsp_err(fp_rsp_err[0]),
    .i_p1_req_valid(fp_valid[1]), .o_p1_req_ready(fp_ready[1]), .i_p1_addr(11'h000),
    .i_p1_wdata(32'h0), .i_p1_size(2'b10), .i_p1_unsigned(1'b0), .i_p1_we(1'b0),
    .o_p1_rsp_valid(fp_rsp_valid[1]), .i_p1_rsp_ready(1'b1),
    .o_p1_rsp_rdata(fp_rdata[1]), .o_p1_rsp_err(fp_rsp_err[1]),
    .o_mem_addr(fp_mem_addr), .o_mem_wdata(fp_mem_wdata), .o_mem_bmask(fp_mem_bmask),
    .o_mem_wren(fp_mem_wren), .i_mem_rdata(32'h0)
  );

  // Memory: combinational read pre-shifted by the byte offset, byte-masked write.
  always_comb mem_rdata = {mem[mem_addr + 11'd3], mem[mem_addr + 11'd2],
                           mem[mem_addr + 11'd1], mem[mem_addr]};

  always @(posedge clk) begin
    if (mem_wren) begin
      if (mem_bmask[0]) mem[mem_addr]         <= mem_wdata[7:0];
      if (mem_bmask[1]) mem[mem_addr + 11'd1] <= mem_wdata[15:8];
      if (mem_bmask[2]) mem[mem_addr + 11'd2] <= mem_wdata[23:16];
      if (mem_bmask[3]) mem[mem_addr + 11'd3] <= mem_wdata[31:24];
    end
  end

  // Reference: an access of 2**sz bytes is legal iff sz != 3 and addr is a multiple of it.
  function automatic void model_access(input bit w, input logic [1:0] sz, input bit u,
                                       input logic [10:0] a, input logic [31:0] wd,
                                       output bit exp_err, output logic [31:0] exp_d,
                                       output logic [3:0] exp_bm, output bit exp_wren);
    int     n;
    bit     legal;
    longint v;
    n       = 1 << sz;
    legal   = (sz != 2'd3) && ((int'(a) % n) == 0);
    exp_err = !legal;
    exp_d   = 32'h0;
    exp_bm  = 4'h0;
    exp_wren = 1'b0;
    if (legal) begin
      exp_bm   = 4'((1 << n) - 1);
      exp_wren = w;
      if (w) begin
        for (int k = 0; k < n; k++) ref_mem[11'(int'(a) + k)] = wd[8*k +: 8];
      end else begin
        v = 0;
        for (int k = 0; k < n; k++) v += longint'(ref_mem[11'(int'(a) + k)]) << (8*k);
        if (!u && v >= (longint'(1) << (8*n - 1))) v -= (longint'(1) << (8*n));
        exp_d = v[31:0];
      end
    end
  endfunction

  task automatic issue(input int p, input bit w, input logic [1:0] sz, input bit u,
                       input logic [10:0] a, input logic [31:0] wd,
                       output bit granted, output bit g_wren, output logic [3:0] g_bm,
                       output logic r_valid, output logic r_err, output logic [31:0] r_data,
                       output bit wren_after);
    req_valid[p] = 1'b1; we[p] = w; size[p] = sz; zext[p] = u;
    addr[p] = a; wdata[p] = wd; rsp_ready[p] = 1'b1;
    granted = 1'b0; g_wren = 1'b0; g_bm = 4'h0;
    for (int i = 0; i < 16 && !granted; i++) begin
      #1;
      if (req_ready[p]) begin
        granted = 1'b1; g_wren = mem_wren; g_bm = mem_bmask;
      end else begin
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1;
    req_valid[p] = 1'b0;
    #1;
    r_valid = rsp_valid[p]; r_err = rsp_err[p]; r_data = rsp_rdata[p];
    wren_after = mem_wren;
    if (granted) last_grant = p;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req_valid = 2'b11; rsp_ready = 2'b11;
    we = 2'b11; size[0] = 2'b10; size[1] = 2'b00; addr[0] = 11'h7F0; addr[1] = 11'h7F8;
    wdata[0] = 32'h12345678; wdata[1] = 32'h9A;
    repeat (3) begin
      @(posedge clk); #2;
      tests++;
      if (req_ready !== 2'b00) begin
        fails++; $display("FAIL reset_ready got=%b want=00", req_ready);
      end
      tests++;
      if (mem_wren !== 1'b0) begin
        fails++; $display("FAIL reset_wren got=%b want=0", mem_wren);
      end
    end
    tests++;
    if (rsp_valid !== 2'b00 || rsp_err !== 2'b00) begin
      fails++; $display("FAIL reset_rsp valid=%b err=%b want=00/00", rsp_valid, rsp_err);
    end
    tests++;
    if (rsp_rdata[0] !== 32'h0 || rsp_rdata[1] !== 32'h0) begin
      fails++; $display("FAIL reset_rdata got=%h/%h want=0/0", rsp_rdata[0], rsp_rdata[1]);
    end
    req_valid = 2'b00; we = 2'b00;
    reset = 1'b0;
    #1;
  endtask

  typedef struct {
    int          p;
    bit          w;
    logic [1:0]  sz;
    bit          u;
    logic [10:0] a;
    logic [31:0] wd;
    logic [31:0] exp_d;
    bit          exp_err;
  } dir_t;

  task automatic test_directed();
    dir_t tbl [11];
    bit g, gw, wa, me, mw;
    logic [3:0] gb, mb;
    logic rv, re;
    logic [31:0] rd, md;
    tbl[0]  = '{0, 1, 2'b10, 0, 11'h010, 32'hDEADBEEF, 32'h00000000, 0};
    tbl[1]  = '{0, 0, 2'b00, 1, 11'h013, 32'h0,        32'h000000DE, 0};
    tbl[2]  = '{0, 0, 2'b00, 0, 11'h013, 32'h0,        32'hFFFFFFDE, 0};
    tbl[3]  = '{0, 0, 2'b01, 0, 11'h012, 32'h0,        32'hFFFFDEAD, 0};
    tbl[4]  = '{1, 1, 2'b00, 0, 11'h011, 32'h000000AA, 32'h00000000, 0};
    tbl[5]  = '{1, 0, 2'b10, 0, 11'h010, 32'h0,        32'hDEADAAEF, 0};
    tbl[6]  = '{0, 1, 2'b01, 0, 11'h011, 32'h00001234, 32'h00000000, 1};
    tbl[7]  = '{0, 1, 2'b11, 0, 11'h000, 32'h55555555, 32'h00000000, 1};
    tbl[8]  = '{0, 0, 2'b10, 0, 11'h010, 32'h0,        32'hDEADAAEF, 0};
    tbl[9]  = '{1, 0, 2'b01, 1, 11'h012, 32'h0,        32'h0000DEAD, 0};
    tbl[10] = '{1, 0, 2'b10, 0, 11'h012, 32'h0,        32'h00000000, 1};
    foreach (tbl[i]) begin
      model_access(tbl[i].w, tbl[i].sz, tbl[i].u, tbl[i].a, tbl[i].wd, me, md, mb, mw);
      issue(tbl[i].p, tbl[i].w, tbl[i].sz, tbl[i].u, tbl[i].a, tbl[i].wd, g, gw, gb, rv, re, rd, wa);
      tests++;
      if (!g || rv !== 1'b1) begin
        fails++; $display("FAIL dir%0d_accept granted=%0d valid=%b want 1/1", i, g, rv);
      end
      tests++;
      if (re !== tbl[i].exp_err || rd !== tbl[i].exp_d) begin
        fails++;
        $display("FAIL dir%0d_rsp err=%b rdata=%h want err=%b rdata=%h", i, re, rd, tbl[i].exp_err, tbl[i].exp_d);
      end
      tests++;
      if (gw !== mw || gb !== mb || wa !== 1'b0) begin
        fails++;
        $display("FAIL dir%0d_mem wren=%b bmask=%b wren_next=%b want %b/%b/0", i, gw, gb, wa, mw, mb);
      end
    end
  endtask

  task automatic test_random();
    bit g, gw, wa, me, mw, w, u;
    logic [3:0] gb, mb;
    logic rv, re;
    logic [31:0] rd, md, wd;
    logic [1:0] sz;
    logic [10:0] a;
    int p;
    for (int i = 0; i < 200; i++) begin
      p  = int'($urandom_range(0, 1));
      w  = 1'($urandom);
      u  = 1'($urandom);
      sz = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      a  = ($urandom_range(0, 9) == 0) ? 11'($urandom) : 11'($urandom_range(32, 95));
      wd = $urandom;
      model_access(w, sz, u, a, wd, me, md, mb, mw);
      issue(p, w, sz, u, a, wd, g, gw, gb, rv, re, rd, wa);
      tests++;
      if (!g || rv !== 1'b1 || re !== me || rd !== md) begin
        fails++;
        $display("FAIL rnd%0d_rsp p=%0d we=%0d sz=%0d u=%0d a=%h granted=%0d valid=%b err=%b rdata=%h want err=%b rdata=%h",
                 i, p, w, sz, u, a, g, rv, re, rd, me, md);
      end
      tests++;
      if (gw !== mw || gb !== mb) begin
        fails++; $display("FAIL rnd%0d_mem wren=%b bmask=%b want %b/%b", i, gw, gb, mw, mb);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] want;
    for (int p = 0; p < 2; p++) begin
      we[p] = 1'b0; size[p] = 2'b10; zext[p] = 1'b0; addr[p] = 11'(p * 4 + 11'h200);
    end
    rsp_ready = 2'b11;
    req_valid = 2'b11;
    #1;
    for (int i = 0; i < 8; i++) begin
      want = (last_grant == 0) ? 2'b10 : 2'b01;
      tests++;
      if (req_ready !== want) begin
        fails++; $display("FAIL rr_cycle%0d ready=%b want=%b", i, req_ready, want);
      end
      last_grant = (want == 2'b10) ? 1 : 0;
      @(posedge clk); #2;
    end
    req_valid = 2'b00;
    @(posedge clk); #2;
  endtask

  task automatic test_backpressure();
    bit me, mw;
    logic [3:0] mb;
    logic [31:0] exp1, exp2;
    we = 2'b00; zext = 2'b00; size[0] = 2'b10; size[1] = 2'b10;
    addr[1] = 11'h100; rsp_ready[1] = 1'b0; req_valid[1] = 1'b1;
    model_access(1'b0, 2'b10, 1'b0, 11'h100, 32'h0, me, exp1, mb, mw);
    #1;
    tests++;
    if (req_ready !== 2'b10) begin
      fails++; $display("FAIL bp_first ready=%b want=10", req_ready);
    end
    last_grant = 1;
    @(posedge clk); #1;
    addr[1] = 11'h104; addr[0] = 11'h108; rsp_ready[0] = 1'b1; req_valid[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      tests++;
      if (req_ready !== 2'b01) begin
        fails++; $display("FAIL bp_block%0d ready=%b want=01", i, req_ready);
      end
      tests++;
      if (rsp_valid[1] !== 1'b1 || rsp_rdata[1] !== exp1) begin
        fails++; $display("FAIL bp_hold%0d valid=%b rdata=%h want 1/%h", i, rsp_valid[1], rsp_rdata[1], exp1);
      end
      last_grant = 0;
      @(posedge clk); #1;
    end
    rsp_ready[1] = 1'b1;
    model_access(1'b0, 2'b10, 1'b0, 11'h104, 32'h0, me, exp2, mb, mw);
    #1;
    tests++;
    if (req_ready !== 2'b10) begin
      fails++; $display("FAIL bp_release ready=%b want=10", req_ready);
    end
    last_grant = 1;
    @(posedge clk); #1;
    req_valid = 2'b00;
    #1;
    tests++;
    if (rsp_valid[1] !== 1'b1 || rsp_rdata[1] !== exp2) begin
      fails++; $display("FAIL bp_new_rsp valid=%b rdata=%h want 1/%h", rsp_valid[1], rsp_rdata[1], exp2);
    end
    @(posedge clk); #2;
  endtask

  task automatic test_mid_reset();
    we = 2'b00; size[0] = 2'b10; size[1] = 2'b10; addr[0] = 11'h120; addr[1] = 11'h124;
    rsp_ready = 2'b00; req_valid = 2'b11;
    @(posedge clk); @(posedge clk); #1;
    req_valid = 2'b00;
    #1;
    tests++;
    if (rsp_valid !== 2'b11) begin
      fails++; $display("FAIL mrst_pending valid=%b want=11", rsp_valid);
    end
    reset = 1'b1; rsp_ready = 2'b11; req_valid = 2'b11; we[0] = 1'b1;
    #1;
    tests++;
    if (req_ready !== 2'b00 || mem_wren !== 1'b0) begin
      fails++; $display("FAIL mrst_during ready=%b wren=%b want 00/0", req_ready, mem_wren);
    end
    @(posedge clk); #1;
    reset = 1'b0; we[0] = 1'b0;
    #1;
    tests++;
    if (rsp_valid !== 2'b00) begin
      fails++; $display("FAIL mrst_cleared valid=%b want=00", rsp_valid);
    end
    tests++;
    if (req_ready !== 2'b01 || mem_wren !== 1'b0) begin
      fails++; $display("FAIL mrst_first_tie ready=%b wren=%b want 01/0", req_ready, mem_wren);
    end
    last_grant = 0;
    @(posedge clk); #1;
    req_valid = 2'b00;
    @(posedge clk); #2;
  endtask

  task automatic test_fixed_prio();
    fp_valid = 2'b11;
    for (int i = 0; i < 6; i++) begin
      #1;
      tests++;
      if (fp_ready !== 2'b01 || fp_mem_bmask !== 4'b1111 || fp_mem_wren !== 1'b0 ||
          fp_mem_addr !== 11'h0 || fp_mem_wdata !== 32'h0) begin
        fails++;
        $display("FAIL fp_cycle%0d ready=%b bmask=%b wren=%b want 01/1111/0", i, fp_ready, fp_mem_bmask, fp_mem_wren);
      end
      @(posedge clk); #1;
      tests++;
      if (fp_rsp_valid !== 2'b01 || fp_rsp_err !== 2'b00 || fp_rdata[0] !== 32'h0 || fp_rdata[1] !== 32'h0) begin
        fails++;
        $display("FAIL fp_rsp%0d valid=%b err=%b rdata0=%h want 01/00/0", i, fp_rsp_valid, fp_rsp_err, fp_rdata[0]);
      end
    end
    fp_valid = 2'b00;
  endtask

  initial begin
    reset = 1'b1; fp_valid = 2'b00;
    req_valid = 2'b00; rsp_ready = 2'b11; we = 2'b00; zext = 2'b00;
    for (int p = 0; p < 2; p++) begin
      addr[p] = 11'h0; wdata[p] = 32'h0; size[p] = 2'b00;
    end
    test_reset();
    test_directed();
    test_random();
    test_round_robin();
    test_backpressure();
    test_mid_reset();
    test_fixed_prio();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
